// File: rtl/stream_upsizer_pkg.sv
// ---------------------------------------------------------------------------
// stream_upsizer_pkg
//   Shared helpers for the stream width converters.
//   clog2_min1 : ceil(log2(n)) clamped to at least 1, so that a lane counter
//                for a single-lane configuration still has a legal width.
// ---------------------------------------------------------------------------
package stream_upsizer_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// ---------------------------------------------------------------------------
// stream_upsizer
//   Packs SCALE consecutive DW_IN-bit stream words into one DW_IN*SCALE-bit
//   word. Lane 0 (lowest bits) carries the first narrow word received.
//   s_last_i closes a partially filled wide word early; m_keep_o marks the
//   lanes that carry data, and m_last_o propagates the packet end.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   s_data_i   in   narrow input word
//   s_valid_i  in   input valid
//   s_last_i   in   input word ends a packet
//   s_ready_o  out  input ready (combinational from m_ready_i)
//   m_data_o   out  wide output word
//   m_keep_o   out  per-lane data-present flags
//   m_last_o   out  wide word ends a packet
//   m_valid_o  out  output valid
//   m_ready_i  in   output ready
// ---------------------------------------------------------------------------
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int DW_IN = 16,
    parameter int SCALE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DW_IN-1:0]       s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [DW_IN*SCALE-1:0] m_data_o,
    output logic [SCALE-1:0]       m_keep_o,
    output logic                   m_last_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);

    localparam int             DW_OUT    = DW_IN * SCALE;
    localparam int             CW        = clog2_min1(SCALE);
    localparam logic [CW-1:0]  LAST_LANE = CW'(SCALE - 1);

    logic [CW-1:0]     cnt;
    // Full output width; lanes at or above cnt are always zero, so OR-ing the
    // incoming lane in produces the packed word without any masking.
    logic [DW_OUT-1:0] acc;
    logic [DW_OUT-1:0] lane_word;
    logic [SCALE-1:0]  keep_next;
    logic              closing;
    logic              accept;
    logic              take;

    assign closing   = (cnt == LAST_LANE) || s_last_i;
    // Only a closing word needs the output register; it may load on the same
    // edge the current word leaves, hence the direct m_ready_i term.
    assign s_ready_o = !closing || !m_valid_o || m_ready_i;
    assign accept    = s_valid_i && s_ready_o;
    assign take      = m_valid_o && m_ready_i;
    assign lane_word = DW_OUT'(s_data_i) << (int'(cnt) * DW_IN);

    always_comb begin
        keep_next = '0;
        for (int k = 0; k < SCALE; k++) begin
            keep_next[k] = (k <= int'(cnt));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= closing ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= closing ? '0 : (acc | lane_word);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else if (accept && closing) begin
            m_data_o  <= acc | lane_word;
            m_keep_o  <= keep_next;
            m_last_o  <= s_last_i;
            m_valid_o <= 1'b1;
        end else if (take) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// ---------------------------------------------------------------------------
// tb_stream_upsizer
//   Directed bench for stream_upsizer: a DW_IN=16/SCALE=3 instance covers
//   packing, partial words, back-pressure and reset; a SCALE=1 instance
//   covers the pass-through register configuration.
// ---------------------------------------------------------------------------
module tb_stream_upsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_data;
    logic        s_valid, s_last, s_ready;
    logic [47:0] m_data;
    logic [2:0]  m_keep;
    logic        m_last, m_valid, m_ready;

    logic [15:0] s1_data;
    logic        s1_valid, s1_last, s1_ready;
    logic [15:0] m1_data;
    logic [0:0]  m1_keep;
    logic        m1_last, m1_valid, m1_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [51:0] got_q[$];

    always #5 clk = ~clk;

    stream_upsizer #(.DW_IN(16), .SCALE(3)) u3 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_keep_o(m_keep), .m_last_o(m_last), .m_valid_o(m_valid),
        .m_ready_i(m_ready)
    );

    stream_upsizer #(.DW_IN(16), .SCALE(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s1_data), .s_valid_i(s1_valid), .s_last_i(s1_last), .s_ready_o(s1_ready),
        .m_data_o(m1_data), .m_keep_o(m1_keep), .m_last_o(m1_last), .m_valid_o(m1_valid),
        .m_ready_i(m1_ready)
    );

    // Inputs change 1 ns after the rising edge, so the falling edge sees the
    // values that the next rising edge will act on.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got_q.push_back({m_last, m_keep, m_data});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
    endtask

    task automatic idle;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0; m1_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid_low: got %0h expected 0", m_valid); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %0h expected 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %0h expected 0", m_valid); end
        n_cmp++; if (m_data !== 48'h0) begin n_bad++; $display("FAIL reset_m_data: got %0h expected 0", m_data); end
        n_cmp++; if (m_keep !== 3'b000) begin n_bad++; $display("FAIL reset_m_keep: got %0h expected 0", m_keep); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_m_last: got %0h expected 0", m_last); end
        n_cmp++; if (m1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m1_valid: got %0h expected 0", m1_valid); end
    endtask

    task automatic test_full_word;
        m_ready = 1'b1;
        got_q.delete();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_early: got %0h expected 0", m_valid); end
        s_data = 16'h3333;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_s_ready: got %0h expected 1", s_ready); end
        tick();
        idle();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %0h expected 1", m_valid); end
        n_cmp++; if (m_data !== 48'h3333_2222_1111) begin n_bad++; $display("FAIL full_data: got %0h expected 333322221111", m_data); end
        n_cmp++; if (m_keep !== 3'b111) begin n_bad++; $display("FAIL full_keep: got %0h expected 7", m_keep); end
        n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL full_last: got %0h expected 0", m_last); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_drop: got %0h expected 0", m_valid); end
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL full_count: got %0d expected 1", got_q.size()); end
    endtask

    task automatic test_back_to_back;
        logic [51:0] exp_w[4];
        logic        ready_ok;
        exp_w[0] = {1'b0, 3'b111, 48'h0003_0002_0001};
        exp_w[1] = {1'b0, 3'b111, 48'h0006_0005_0004};
        exp_w[2] = {1'b0, 3'b111, 48'h0009_0008_0007};
        exp_w[3] = {1'b0, 3'b111, 48'h000C_000B_000A};
        m_ready  = 1'b1;
        ready_ok = 1'b1;
        got_q.delete();
        for (int i = 1; i <= 12; i++) begin
            s_valid = 1'b1; s_last = 1'b0; s_data = 16'(i);
            #1;
            if (!s_ready) ready_ok = 1'b0;
            tick();
        end
        idle();
        repeat (3) tick();
        n_cmp++; if (ready_ok !== 1'b1) begin n_bad++; $display("FAIL b2b_s_ready_never_low: got %0h expected 1", ready_ok); end
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL b2b_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== exp_w[i]) begin n_bad++; $display("FAIL b2b_word%0d: got %0h expected %0h", i, got_q[i], exp_w[i]); end
        end
    endtask

    task automatic test_stalls;
        logic [15:0] words[6];
        logic [15:0] vpat, rpat;
        logic [47:0] pd;
        logic [2:0]  pk;
        logic        pl, hold, acc;
        int          sent;
        words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
        words[3] = 16'hA004; words[4] = 16'hA005; words[5] = 16'hA006;
        vpat = 16'b0101_1010_0110_1001;
        rpat = 16'b0010_0100_1001_0010;
        sent = 0;
        got_q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sent == 6 && got_q.size() == 2) break;
            s_valid = vpat[cyc % 16] && (sent < 6);
            s_data  = words[(sent < 6) ? sent : 5];
            s_last  = 1'b0;
            m_ready = rpat[cyc % 16];
            #1;
            acc  = s_valid && s_ready;
            hold = m_valid && !m_ready;
            pd = m_data; pk = m_keep; pl = m_last;
            tick();
            if (acc) sent++;
            if (hold) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== pd || m_keep !== pk || m_last !== pl) begin
                    n_bad++;
                    $display("FAIL stall_stable: got v=%0h d=%0h k=%0h l=%0h expected v=1 d=%0h k=%0h l=%0h",
                             m_valid, m_data, m_keep, m_last, pd, pk, pl);
                end
            end
        end
        idle();
        m_ready = 1'b1;
        n_cmp++; if (sent != 6) begin n_bad++; $display("FAIL stall_sent: got %0d expected 6", sent); end
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL stall_count: got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_cmp++; if (got_q[0] !== {1'b0, 3'b111, 48'hA003_A002_A001}) begin n_bad++; $display("FAIL stall_word0: got %0h expected 7a003a002a001", got_q[0]); end
            n_cmp++; if (got_q[1] !== {1'b0, 3'b111, 48'hA006_A005_A004}) begin n_bad++; $display("FAIL stall_word1: got %0h expected 7a006a005a004", got_q[1]); end
        end
        tick();
    endtask

    task automatic test_last;
        m_ready = 1'b1;
        got_q.delete();
        send(16'hAAAA, 1'b0);
        send(16'hBBBB, 1'b1);
        idle();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL last_valid: got %0h expected 1", m_valid); end
        n_cmp++; if (m_data !== 48'h0000_BBBB_AAAA) begin n_bad++; $display("FAIL last_data: got %0h expected 0000bbbbaaaa", m_data); end
        n_cmp++; if (m_keep !== 3'b011) begin n_bad++; $display("FAIL last_keep: got %0h expected 3", m_keep); end
        n_cmp++; if (m_last !== 1'b1) begin n_bad++; $display("FAIL last_flag: got %0h expected 1", m_last); end
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b0);
        send(16'h4444, 1'b1);
        idle();
        repeat (3) tick();
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL last_count: got %0d expected 3", got_q.size()); end
        if (got_q.size() >= 3) begin
            n_cmp++; if (got_q[1] !== {1'b0, 3'b111, 48'h0003_0002_0001}) begin n_bad++; $display("FAIL last_restart: got %0h expected 7000300020001", got_q[1]); end
            n_cmp++; if (got_q[2] !== {1'b1, 3'b001, 48'h0000_0000_4444}) begin n_bad++; $display("FAIL last_single_lane: got %0h expected 9000000004444", got_q[2]); end
        end
    endtask

    task automatic test_backpressure;
        m_ready = 1'b0;
        got_q.delete();
        send(16'h0007, 1'b0);
        send(16'h0008, 1'b0);
        send(16'h0009, 1'b0);
        idle();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_full_held: got %0h expected 1", m_valid); end
        s_valid = 1'b1; s_data = 16'h0001;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_w1: got %0h expected 1", s_ready); end
        tick();
        s_data = 16'h0002;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_w2: got %0h expected 1", s_ready); end
        tick();
        s_data = 16'h0003;
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_w3: got %0h expected 0", s_ready); end
        repeat (3) tick();
        n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_w3_hold: got %0h expected 0", s_ready); end
        n_cmp++; if (m_data !== 48'h0009_0008_0007) begin n_bad++; $display("FAIL bp_data_hold: got %0h expected 000900080007", m_data); end
        m_ready = 1'b1;
        #1;
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_release: got %0h expected 1", s_ready); end
        tick();
        idle();
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_swap_valid: got %0h expected 1", m_valid); end
        n_cmp++; if (m_data !== 48'h0003_0002_0001) begin n_bad++; $display("FAIL bp_swap_data: got %0h expected 000300020001", m_data); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %0h expected 0", m_valid); end
        n_cmp++; if (got_q.size() != 2) begin n_bad++; $display("FAIL bp_count: got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== {1'b0, 3'b111, 48'h0009_0008_0007}) begin n_bad++; $display("FAIL bp_word0: got %0h expected 7000900080007", got_q[0]); end
        end
    endtask

    task automatic test_reset_mid_word;
        m_ready = 1'b1;
        got_q.delete();
        send(16'h0011, 1'b0);
        send(16'h0022, 1'b0);
        idle();
        rst_n = 1'b0;
        #2;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %0h expected 0", m_valid); end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send(16'h0005, 1'b0);
        send(16'h0006, 1'b0);
        send(16'h0007, 1'b0);
        idle();
        repeat (3) tick();
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL rst_mid_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== {1'b0, 3'b111, 48'h0007_0006_0005}) begin n_bad++; $display("FAIL rst_mid_word: got %0h expected 7000700060005", got_q[0]); end
        end
    endtask

    task automatic test_scale1;
        m1_ready = 1'b1;
        s1_valid = 1'b1; s1_data = 16'h1234; s1_last = 1'b0;
        #1;
        n_cmp++; if (s1_ready !== 1'b1) begin n_bad++; $display("FAIL s1_ready: got %0h expected 1", s1_ready); end
        tick();
        n_cmp++; if (m1_valid !== 1'b1) begin n_bad++; $display("FAIL s1_valid_w0: got %0h expected 1", m1_valid); end
        n_cmp++; if (m1_data !== 16'h1234) begin n_bad++; $display("FAIL s1_data_w0: got %0h expected 1234", m1_data); end
        n_cmp++; if (m1_keep !== 1'b1) begin n_bad++; $display("FAIL s1_keep_w0: got %0h expected 1", m1_keep); end
        n_cmp++; if (m1_last !== 1'b0) begin n_bad++; $display("FAIL s1_last_w0: got %0h expected 0", m1_last); end
        s1_data = 16'h5678; s1_last = 1'b1;
        tick();
        n_cmp++; if (m1_data !== 16'h5678) begin n_bad++; $display("FAIL s1_data_w1: got %0h expected 5678", m1_data); end
        n_cmp++; if (m1_last !== 1'b1) begin n_bad++; $display("FAIL s1_last_w1: got %0h expected 1", m1_last); end
        s1_valid = 1'b0; s1_last = 1'b0;
        tick();
        n_cmp++; if (m1_valid !== 1'b0) begin n_bad++; $display("FAIL s1_drain: got %0h expected 0", m1_valid); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_stalls();
        test_last();
        test_backpressure();
        test_reset_mid_word();
        test_scale1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
